// File: rtl/conv_8_4_host.sv
// Host-side driver/sink for conv_8_4: replays stored x/f vectors as valid/ready
// master streams and captures the y result stream into a readable buffer.
module conv_8_4_host #(
  parameter  int X_LEN = 8,
  parameter  int F_LEN = 4,
  parameter  int W     = 8,
  parameter  int YW    = 18,
  localparam int AW    = $clog2(X_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_wr_en,
  input  logic          cfg_wr_sel,
  input  logic [AW-1:0] cfg_wr_addr,
  input  logic [W-1:0]  cfg_wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  m_data_out_x,
  output logic          m_valid_x,
  input  logic          m_ready_x,
  output logic [W-1:0]  m_data_out_f,
  output logic          m_valid_f,
  input  logic          m_ready_f,
  input  logic [YW-1:0] s_data_in_y,
  input  logic          s_valid_y,
  output logic          s_ready_y,
  input  logic [AW-1:0] rd_addr,
  output logic [YW-1:0] rd_data
);
  localparam int Y_LEN = X_LEN - F_LEN + 1;
  localparam int FAW   = $clog2(F_LEN);
  localparam int YAW   = $clog2(Y_LEN);
  localparam int CW    = AW + 1;
  localparam logic [CW-1:0] XL = CW'(X_LEN);
  localparam logic [CW-1:0] FL = CW'(F_LEN);
  localparam logic [CW-1:0] YL = CW'(Y_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] x_idx_q, x_idx_d, f_idx_q, f_idx_d, y_idx_q, y_idx_d;
  logic [W-1:0]  xbuf_q [X_LEN];
  logic [W-1:0]  fbuf_q [F_LEN];
  logic [YW-1:0] ybuf_q [Y_LEN];
  logic [YW-1:0] rd_data_q;
  logic          run, x_fire, f_fire, y_fire, wr_ok;

  assign run          = (state_q == RUN);
  assign busy         = run;
  assign done         = (state_q == DONE);
  assign m_valid_x    = run && (x_idx_q < XL);
  assign m_valid_f    = run && (f_idx_q < FL);
  assign s_ready_y    = run && (y_idx_q < YL);
  assign m_data_out_x = m_valid_x ? xbuf_q[x_idx_q[AW-1:0]] : '0;
  assign m_data_out_f = m_valid_f ? fbuf_q[f_idx_q[FAW-1:0]] : '0;
  assign x_fire       = m_valid_x && m_ready_x;
  assign f_fire       = m_valid_f && m_ready_f;
  assign y_fire       = s_valid_y && s_ready_y;
  assign wr_ok        = cfg_wr_en && !run;
  assign rd_data      = rd_data_q;

  always_comb begin
    state_d = state_q;
    x_idx_d = x_idx_q;
    f_idx_d = f_idx_q;
    y_idx_d = y_idx_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        x_idx_d = '0;
        f_idx_d = '0;
        y_idx_d = '0;
      end
      RUN: begin
        x_idx_d = x_idx_q + CW'(x_fire);
        f_idx_d = f_idx_q + CW'(f_fire);
        y_idx_d = y_idx_q + CW'(y_fire);
        // Leave on the edge that completes the last outstanding stream, whichever it is.
        if (x_idx_d == XL && f_idx_d == FL && y_idx_d == YL) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      x_idx_q   <= '0;
      f_idx_q   <= '0;
      y_idx_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      x_idx_q   <= x_idx_d;
      f_idx_q   <= f_idx_d;
      y_idx_q   <= y_idx_d;
      rd_data_q <= ({1'b0, rd_addr} < YL) ? ybuf_q[rd_addr[YAW-1:0]] : '0;
    end
  end

  // Sample storage deliberately sits outside reset so a reset never loses loaded vectors.
  always_ff @(posedge clk) begin
    if (wr_ok && !cfg_wr_sel) xbuf_q[cfg_wr_addr] <= cfg_wr_data;
    if (wr_ok && cfg_wr_sel && ({1'b0, cfg_wr_addr} < FL))
      fbuf_q[cfg_wr_addr[FAW-1:0]] <= cfg_wr_data;
    if (y_fire) ybuf_q[y_idx_q[YAW-1:0]] <= s_data_in_y;
  end
endmodule

// File: tb/tb_conv_8_4_host.sv
// Randomized bench for conv_8_4_host: a behavioural stream/buffer model plus a
// per-cycle compare process, with literal expectations for the reference vectors.
module tb_conv_8_4_host;
  logic        clk = 0, reset = 1;
  logic        cfg_wr_en = 0, cfg_wr_sel = 0, start = 0;
  logic [2:0]  cfg_wr_addr = 0, rd_addr = 0;
  logic [7:0]  cfg_wr_data = 0;
  logic        busy, done;
  logic [7:0]  m_data_out_x, m_data_out_f;
  logic        m_valid_x, m_valid_f, s_ready_y;
  logic        m_ready_x = 0, m_ready_f = 0, s_valid_y = 0;
  logic [17:0] s_data_in_y = 0, rd_data;

  conv_8_4_host dut (
    .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .start(start),
    .busy(busy), .done(done),
    .m_data_out_x(m_data_out_x), .m_valid_x(m_valid_x), .m_ready_x(m_ready_x),
    .m_data_out_f(m_data_out_f), .m_valid_f(m_valid_f), .m_ready_f(m_ready_f),
    .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y), .s_ready_y(s_ready_y),
    .rd_addr(rd_addr), .rd_data(rd_data));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0=idle 1=run 2=done, beat counts per stream.
  int xm[8], fm[4], ym[5];
  bit ym_ok[5];
  int mph, mnx, mnf, mny, rd_exp;
  bit rd_ok;

  function automatic int yref(int n);
    int s = 0;
    for (int k = 0; k < 4; k++) s += xm[n+k] * fm[k];
    return s;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mph <= 0; mnx <= 0; mnf <= 0; mny <= 0; rd_exp <= 0; rd_ok <= 1;
    end else begin
      rd_ok  <= (rd_addr < 5) && ym_ok[rd_addr];
      rd_exp <= (rd_addr < 5) ? ym[rd_addr] : 0;
      if (mph == 1) begin
        int nx, nf, ny;
        nx = mnx + ((mnx < 8 && m_ready_x) ? 1 : 0);
        nf = mnf + ((mnf < 4 && m_ready_f) ? 1 : 0);
        ny = mny;
        if (mny < 5 && s_valid_y) begin
          ym[mny] <= int'($signed(s_data_in_y));
          ym_ok[mny] <= 1;
          ny = mny + 1;
        end
        mnx <= nx; mnf <= nf; mny <= ny;
        if (nx == 8 && nf == 4 && ny == 5) mph <= 2;
      end else begin
        if (cfg_wr_en && !cfg_wr_sel) xm[cfg_wr_addr] <= int'($signed(cfg_wr_data));
        if (cfg_wr_en && cfg_wr_sel && cfg_wr_addr < 4) fm[cfg_wr_addr] <= int'($signed(cfg_wr_data));
        if (mph == 2) mph <= 0;
        else if (start) begin mph <= 1; mnx <= 0; mnf <= 0; mny <= 0; end
      end
    end
  end

  // Per-cycle compare, plus handshake/pulse counters for the directed tests.
  int hs_x, hs_f, hs_y, done_cnt, busy_cnt;
  always @(negedge clk) begin
    chk("busy", int'(busy), int'(mph == 1));
    chk("done", int'(done), int'(mph == 2));
    chk("valid_x", int'(m_valid_x), int'(mph == 1 && mnx < 8));
    chk("data_x", int'($signed(m_data_out_x)), (mph == 1 && mnx < 8) ? xm[mnx] : 0);
    chk("valid_f", int'(m_valid_f), int'(mph == 1 && mnf < 4));
    chk("data_f", int'($signed(m_data_out_f)), (mph == 1 && mnf < 4) ? fm[mnf] : 0);
    chk("ready_y", int'(s_ready_y), int'(mph == 1 && mny < 5));
    if (rd_ok) chk("rd_data", int'($signed(rd_data)), rd_exp);
    hs_x += int'(m_valid_x && m_ready_x);
    hs_f += int'(m_valid_f && m_ready_f);
    hs_y += int'(s_valid_y && s_ready_y);
    done_cnt += int'(done);
    busy_cnt += int'(busy);
  end

  // Source/sink behaviour re-driven just after every rising edge.
  bit rnd = 0, hold_x = 0, extra_y = 0;
  task automatic tick();
    @(posedge clk); #1;
    m_ready_x = hold_x ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    m_ready_f = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mny < 5) begin
      s_valid_y   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_in_y = 18'(yref(mny));
    end else begin
      s_valid_y   = extra_y;
      s_data_in_y = 18'h01234;
    end
  endtask

  task automatic wr(bit sel, int addr, int data);
    cfg_wr_en = 1; cfg_wr_sel = sel; cfg_wr_addr = 3'(addr); cfg_wr_data = 8'(data);
    tick();
    cfg_wr_en = 0;
  endtask

  task automatic go();
    start = 1; tick(); start = 0;
  endtask

  task automatic clr_cnt();
    hs_x = 0; hs_f = 0; hs_y = 0; done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic wait_done(string nm);
    int n = 0;
    while (!done && n < 300) begin tick(); n++; end
    chk({nm, "_done_seen"}, int'(done), 1);
    tick();
    chk({nm, "_busy_after"}, int'(busy), 0);
  endtask

  task automatic read_y(string nm);
    int exp_y[5] = '{-2800, 3600, 400, 1600, 2800};
    for (int i = 0; i < 5; i++) begin
      rd_addr = 3'(i); tick();
      chk({nm, "_ybuf"}, int'($signed(rd_data)), exp_y[i]);
    end
  endtask

  initial begin
    int xv[8] = '{10, -20, 30, -40, 50, 60, 70, 80};
    int fv[4] = '{10, 20, -30, 40};
    int n;
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid_x", int'(m_valid_x), 0);
    chk("rst_ready_y", int'(s_ready_y), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    reset = 0;
    for (int i = 0; i < 8; i++) wr(0, i, xv[i]);
    for (int i = 0; i < 4; i++) wr(1, i, fv[i]);
    wr(1, 5, 99);
    chk("model_y1", yref(1), 3600);

    // Stream order, all readies high.
    clr_cnt(); go();
    chk("first_x", int'($signed(m_data_out_x)), 10);
    wait_done("order");
    chk("order_busy_cycles", busy_cnt, 8);
    chk("order_hs_x", hs_x, 8);
    read_y("order");

    // Backpressure plus ignored start/write in RUN.
    rnd = 1; clr_cnt(); go(); tick();
    start = 1; wr(0, 0, 99); start = 0;
    chk("ign_busy", int'(busy), 1);
    wait_done("bp");
    chk("bp_hs_x", hs_x, 8);
    chk("bp_hs_f", hs_f, 4);
    chk("bp_hs_y", hs_y, 5);
    chk("bp_done_pulses", done_cnt, 1);
    read_y("bp");
    go();
    chk("rerun_first_x", int'($signed(m_data_out_x)), 10);
    wait_done("rerun");

    // Reset mid-run after three x beats.
    rnd = 0; go();
    n = 0;
    while (mnx < 3 && n < 50) begin tick(); n++; end
    chk("mid_x_beats", mnx, 3);
    reset = 1; #1;
    chk("mid_rst_valid_x", int'(m_valid_x), 0);
    chk("mid_rst_valid_f", int'(m_valid_f), 0);
    chk("mid_rst_ready_y", int'(s_ready_y), 0);
    chk("mid_rst_busy", int'(busy), 0);
    tick(); reset = 0; tick();
    go();
    chk("post_rst_first_x", int'($signed(m_data_out_x)), 10);
    wait_done("post_rst");

    // y completes before x; a sixth y beat is refused; then replay without reload.
    hold_x = 1; go();
    n = 0;
    while (mny < 5 && n < 50) begin tick(); n++; end
    extra_y = 1; tick(); tick();
    chk("ovf_ready_y", int'(s_ready_y), 0);
    chk("ovf_busy", int'(busy), 1);
    hold_x = 0;
    wait_done("ovf");
    extra_y = 0;
    read_y("ovf");
    clr_cnt(); go();
    wait_done("replay");
    chk("replay_hs_x", hs_x, 8);
    read_y("replay");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_8_4_host.md
# conv_8_4_host

Synthesizable host-side counterpart of the `conv_8_4` streaming interfaces. It holds one x vector and one f vector loaded through a simple write port. On `start` it transmits them as valid/ready master streams into the convolver's x and f inputs. It also acts as the ready/valid sink for the y output stream, capturing results into a readable buffer. It sits between a control/register interface and `conv_8_4`, replacing the bench-driven stimulus/response path in hardware.

## Interface
- `X_LEN`, 8, x vector length
- `F_LEN`, 4, f vector length
- `W`, 8, signed x/f sample width
- `YW`, 18, signed y sample width
- Derived (localparam): `Y_LEN = X_LEN-F_LEN+1` (5); `AW = $clog2(X_LEN)` (3)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all control state
- `cfg_wr_en`  in  1  write strobe for vector buffers
- `cfg_wr_sel`  in  1  0 = x buffer, 1 = f buffer
- `cfg_wr_addr`  in  AW  buffer index
- `cfg_wr_data`  in  W  signed sample
- `start`  in  1  begin one convolution transfer
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse on completion
- `m_data_out_x`  out  W  x stream data
- `m_valid_x`  out  1  x stream valid
- `m_ready_x`  in  1  x stream ready
- `m_data_out_f`  out  W  f stream data
- `m_valid_f`  out  1  f stream valid
- `m_ready_f`  in  1  f stream ready
- `s_data_in_y`  in  YW  y stream data
- `s_valid_y`  in  1  y stream valid
- `s_ready_y`  out  1  y stream ready
- `rd_addr`  in  AW  y buffer read index
- `rd_data`  out  YW  y buffer read data, registered

## Operation
- **State machine:** IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1 at an edge. `x_idx`, `f_idx` and `y_idx` are cleared.
  - RUN → DONE at the edge where the last outstanding handshake completes: `x_idx==X_LEN`, `f_idx==F_LEN` and `y_idx==Y_LEN`.
  - DONE → IDLE unconditionally after one cycle.
- **x stream:** `m_valid_x` = (RUN && `x_idx`<X_LEN). `m_data_out_x` = xbuf[`x_idx`] when valid, else 0. `x_idx` increments only on `m_valid_x && m_ready_x`.
- **f stream:** identical rules using `F_LEN`, `f_idx` and fbuf.
- **y stream:** `s_ready_y` = (RUN && `y_idx`<Y_LEN). On `s_valid_y && s_ready_y`, `s_data_in_y` is written to ybuf[`y_idx`] and `y_idx` increments.
- **Stream independence:** the three streams are independent. Any ordering or interleaving of handshakes is accepted, and y beats may arrive before x/f finish. Extra y beats beyond `Y_LEN` are refused (ready low).
- **Buffer writes:** `cfg_wr_en` is honoured only in IDLE and DONE and is ignored in RUN. f writes with `cfg_wr_addr`≥F_LEN are ignored.
- **Ignored start:** `start` in RUN or DONE is ignored, not queued.
- **Buffer contents:** x, f and y buffers are not affected by `reset`. A new `start` replays the current x/f contents and overwrites ybuf.
- **Arithmetic:** none; the block does pure data movement. Samples are passed bit-exact, signed.

## Timing
- **Reset values:** `busy`=0, `done`=0, `m_valid_x`=0, `m_valid_f`=0, `s_ready_y`=0, `m_data_out_x`=0, `m_data_out_f`=0, `rd_data`=0. State = IDLE and all indices = 0.
- **Start latency:** `start` is sampled at edge N. `busy`, `m_valid_x`, `m_valid_f` and `s_ready_y` are high from just after edge N.
- **Throughput:** one beat per cycle per stream. With ready held high, x completes in X_LEN cycles and f in F_LEN cycles.
- **Stall stability:** while valid=1 and ready=0, data and valid hold stable. Valid never drops before its handshake completes.
- **Completion:** if the final handshake occurs at edge M, DONE holds for the cycle after M. In that cycle `done`=1, `busy`=0 and all valids/ready are 0. A simultaneous final handshake on all three streams still gives a single `done` pulse.
- **Read port:** `rd_data` = ybuf[`rd_addr`] registered, so it appears one cycle after the address. Reads are legal in any state.
- **Reset mid-RUN:** all outputs drop asynchronously to their reset values. A partially delivered vector is abandoned. The next `start` restarts from index 0.

## Test plan
- **Stream order:** load x={10,-20,30,-40,50,60,70,80} and f={10,20,-30,40}, with all readies held at 1 and a model y source → x beats appear in 8 consecutive cycles starting the cycle after `start`, in order, and f beats appear in 4 consecutive cycles.
- **Backpressure:** randomize `m_ready_x`/`m_ready_f` at 50% → data stays stable across stalls, no beat is dropped or duplicated, and exactly 8 x and 4 f handshakes occur.
- **Integration:** connect to `conv_8_4` with random y stalls → ybuf[0..4] reads back -2800, 3600, 400, 1600, 2800; `done` pulses exactly once; `busy` is 0 afterwards.
- **Ignored inputs:** assert `start` and write x[0]=99 during RUN → no restart; rerun still sends x[0]=10.
- **Reset mid-run:** assert `reset` after 3 x beats → valids, `s_ready_y` and `busy` go low immediately. After the next `start`, the first x beat is 10.
- **Overflow and replay:** the source offers a 6th y beat, then a second `start` follows without reload → `s_ready_y`=0 for the 6th beat; the replay sends identical streams and ybuf is overwritten with the same values.
